// File: rtl/tdm_share_pkg.sv
// Shared types and constants for the time-division shared-accumulator arbiter.
package tdm_share_pkg;

  // Slot schedule states; the scrub states are only entered when
  // TDM_SHARE_SCRUB_EN is defined.
  typedef enum logic [1:0] {
    L_SLOT   = 2'd0,
    SCRUB_LH = 2'd1,
    H_SLOT   = 2'd2,
    SCRUB_HL = 2'd3
  } state_e;

  // Domain encoding on the dom output.
  localparam logic DOM_L = 1'b0;
  localparam logic DOM_H = 1'b1;

  // Operation encoding on op_l / op_h.
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_ACC  = 1'b1;

endpackage

// File: rtl/tdm_slot_timer.sv
// Fixed TDM slot schedule: state, slot counter and domain owner.
// No data inputs reach this block, so every output is public-timing only.
// Build option: TDM_SHARE_SCRUB_EN inserts a one-cycle scrub state between slots.
module tdm_slot_timer
  import tdm_share_pkg::*;
#(
  parameter int SLOT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  output state_e     state_o,
  output logic [3:0] slot_cnt_o,
  output logic       dom_o
);

  localparam logic [3:0] LAST_CNT = 4'(SLOT_LEN - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       dom_q;

  // Schedule FSM: advances on slot_cnt alone; dom flips when entering the next owner's scrub (or slot).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= L_SLOT;
      cnt_q   <= 4'd0;
      dom_q   <= DOM_L;
    end else begin
      case (state_q)
        L_SLOT: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= 4'd0;
            dom_q <= DOM_H;
`ifdef TDM_SHARE_SCRUB_EN
            state_q <= SCRUB_LH;
`else
            state_q <= H_SLOT;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SCRUB_LH: begin
          state_q <= H_SLOT;
          cnt_q   <= 4'd0;
          dom_q   <= DOM_H;
        end
        H_SLOT: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= 4'd0;
            dom_q <= DOM_L;
`ifdef TDM_SHARE_SCRUB_EN
            state_q <= SCRUB_HL;
`else
            state_q <= L_SLOT;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SCRUB_HL: begin
          state_q <= L_SLOT;
          cnt_q   <= 4'd0;
          dom_q   <= DOM_L;
        end
        default: begin
          state_q <= L_SLOT;
          cnt_q   <= 4'd0;
          dom_q   <= DOM_L;
        end
      endcase
    end
  end

  assign state_o    = state_q;
  assign slot_cnt_o = cnt_q;
  assign dom_o      = dom_q;

endmodule

// File: rtl/tdm_share_arbiter.sv
// Time-division arbiter owning the shared accumulator register between an
// L and an H requester. The schedule never depends on requests.
// Build option: TDM_SHARE_SCRUB_EN zeroes the register between domains
// (secure build); without it dout carries over across the domain switch.
module tdm_share_arbiter
  import tdm_share_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SLOT_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_l,
  input  logic             op_l,
  input  logic [WIDTH-1:0] din_l,
  input  logic             req_h,
  input  logic             op_h,
  input  logic [WIDTH-1:0] din_h,
  output logic             dom,
  output logic             gnt_l,
  output logic             gnt_h,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [3:0]       slot_cnt
);

  state_e           state_s;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             valid_q;
  logic             valid_d;

  tdm_slot_timer #(
    .SLOT_LEN (SLOT_LEN)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .state_o    (state_s),
    .slot_cnt_o (slot_cnt),
    .dom_o      (dom)
  );

  // A requester is granted only inside its own slot.
  assign gnt_l = req_l & (state_s == L_SLOT);
  assign gnt_h = req_h & (state_s == H_SLOT);

  // Next value of the shared register: serve the granted op, scrub, or hold.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    if (gnt_l) begin
      valid_d = 1'b1;
      if (op_l == OP_ACC) begin
        dout_d = dout_q + din_l;
      end else begin
        dout_d = din_l;
      end
    end else if (gnt_h) begin
      valid_d = 1'b1;
      if (op_h == OP_ACC) begin
        dout_d = dout_q + din_h;
      end else begin
        dout_d = din_h;
      end
    end else begin
`ifdef TDM_SHARE_SCRUB_EN
      if ((state_s == SCRUB_LH) || (state_s == SCRUB_HL)) begin
        dout_d  = {WIDTH{1'b0}};
        valid_d = 1'b0;
      end else begin
        dout_d  = dout_q;
        valid_d = valid_q;
      end
`else
      dout_d  = dout_q;
      valid_d = valid_q;
`endif
    end
  end

  // Shared register; reset discards any operation granted in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_tdm_share_arbiter.sv
// Scoreboard bench for tdm_share_arbiter (WIDTH=4, SLOT_LEN=4).
// Expectations follow the TDM_SHARE_SCRUB_EN build option.
module tb_tdm_share_arbiter;

  localparam int L = 4;
`ifdef TDM_SHARE_SCRUB_EN
  localparam int PER = 2 * L + 2;
`else
  localparam int PER = 2 * L;
`endif
  localparam int NTR = 20 * PER;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_l = 1'b0, op_l = 1'b0, req_h = 1'b0, op_h = 1'b0;
  logic [3:0] din_l = 4'd0, din_h = 4'd0;
  logic       dom, gnt_l, gnt_h, dout_valid;
  logic [3:0] dout, slot_cnt;

  typedef struct packed { logic [3:0] d; logic v; } exp_t;
  exp_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic last_dom, last_gl;
  logic rl_pat [NTR];
  logic dom_tr [NTR];
  logic gl_tr  [NTR];

  tdm_share_arbiter #(.WIDTH(4), .SLOT_LEN(L)) dut (
    .clk(clk), .reset(reset),
    .req_l(req_l), .op_l(op_l), .din_l(din_l),
    .req_h(req_h), .op_h(op_h), .din_h(din_h),
    .dom(dom), .gnt_l(gnt_l), .gnt_h(gnt_h),
    .dout(dout), .dout_valid(dout_valid), .slot_cnt(slot_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected schedule position for cycle c counted from the reset release.
  task automatic sched(input int c, output logic d, output logic [3:0] cnt,
                       output logic in_l, output logic in_h);
    int p;
    p = c % PER;
    in_l = (p < L);
`ifdef TDM_SHARE_SCRUB_EN
    in_h = (p > L) && (p <= 2 * L);
    if (p < L)            begin d = 1'b0; cnt = 4'(p); end
    else if (p == L)      begin d = 1'b1; cnt = 4'd0; end
    else if (p <= 2 * L)  begin d = 1'b1; cnt = 4'(p - L - 1); end
    else                  begin d = 1'b0; cnt = 4'd0; end
`else
    in_h = (p >= L);
    if (p < L) begin d = 1'b0; cnt = 4'(p); end
    else       begin d = 1'b1; cnt = 4'(p - L); end
`endif
  endtask

  // One clock cycle: drive at negedge, check schedule/grants, queue the post-edge register value.
  task automatic step(input logic rst, input logic rl, input logic ol, input logic [3:0] dl,
                      input logic rh, input logic oh, input logic [3:0] dh,
                      input logic egl, input logic egh, input logic [3:0] ed, input logic ev,
                      input logic ck_s, input logic ck_d);
    logic ed_dom, il, ih;
    logic [3:0] ecnt;
    exp_t e;
    @(negedge clk);
    reset = rst; req_l = rl; op_l = ol; din_l = dl; req_h = rh; op_h = oh; din_h = dh;
    #1;
    last_dom = dom;
    last_gl  = gnt_l;
    if (ck_s) begin
      sched(cyc, ed_dom, ecnt, il, ih);
      chk("dom", dom, ed_dom);
      chk("slot_cnt", slot_cnt, ecnt);
      chk("gnt_l", gnt_l, egl);
      chk("gnt_h", gnt_h, egh);
    end
    if (ck_d) begin
      e.d = ed;
      e.v = ev;
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (!rst) cyc = 0;
    else      cyc = cyc + 1;
  endtask

  // Idle cycle with auto-derived grant expectations.
  task automatic idle(input logic [3:0] ed, input logic ev);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ed, ev, 1'b1, 1'b1);
  endtask

  // Monitor: after each edge, compare the register against the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("dout", dout, e.d);
        chk("dout_valid", dout_valid, e.v);
      end
    end
  end

  // Random run over NTR cycles; records dom and gnt_l traces.
  task automatic trace_run(input logic use_h, input logic cmp);
    logic ed_dom, il, ih, rh;
    logic [3:0] ecnt;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NTR; i++) begin
      sched(cyc, ed_dom, ecnt, il, ih);
      rh = use_h ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1'b1, rl_pat[i], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           rh, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           rl_pat[i] & il, rh & ih, 4'd0, 1'b0, 1'b1, 1'b0);
      if (cmp) begin
        chk("trace_dom", last_dom, dom_tr[i]);
        chk("trace_gnt_l", last_gl, gl_tr[i]);
      end else begin
        dom_tr[i] = last_dom;
        gl_tr[i]  = last_gl;
      end
    end
  endtask

  initial begin : stim
    // Reset, state unknown before the first edge.
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    //   rst   rl    ol    dl     rh    oh    dh     egl   egh   dout   valid
`ifdef TDM_SHARE_SCRUB_EN
    step(1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b1); // c0 L load 3
    step(1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 4'd7,  1'b1, 1'b0, 4'd8,  1'b1, 1'b1, 1'b1); // c1 acc 5, H waits
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 4'd8,  1'b1, 1'b1, 1'b1); // c2
    step(1'b1, 1'b1, 1'b0, 4'd12, 1'b1, 1'b0, 4'd7,  1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 1'b1); // c3 last L cycle
    step(1'b1, 1'b1, 1'b1, 4'd9,  1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1); // c4 SCRUB_LH
    step(1'b1, 1'b1, 1'b1, 4'd9,  1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 4'd7,  1'b1, 1'b1, 1'b1); // c5 H load 7
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd12, 1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1); // c6 H load 12
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd9,  1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 1'b1); // c7 12+9 wraps
    idle(4'd5, 1'b1);                                                                        // c8
    idle(4'd0, 1'b0);                                                                        // c9 SCRUB_HL
    step(1'b1, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd2,  1'b1, 1'b1, 1'b1); // c10 acc onto 0
    idle(4'd2, 1'b1); idle(4'd2, 1'b1); idle(4'd2, 1'b1);                                   // c11..c13
    idle(4'd0, 1'b0); idle(4'd0, 1'b0);                                                     // c14, c15
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd6,  1'b0, 1'b1, 4'd6,  1'b1, 1'b1, 1'b1); // c16 H load 6
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1); // c17 reset wins
`else
    step(1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b1); // c0 L load 3
    step(1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 4'd7,  1'b1, 1'b0, 4'd8,  1'b1, 1'b1, 1'b1); // c1 acc 5, H waits
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 4'd8,  1'b1, 1'b1, 1'b1); // c2
    step(1'b1, 1'b1, 1'b0, 4'd12, 1'b1, 1'b0, 4'd7,  1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 1'b1); // c3 last L cycle
    step(1'b1, 1'b1, 1'b1, 4'd9,  1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 4'd7,  1'b1, 1'b1, 1'b1); // c4 H load 7
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd12, 1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1); // c5 H load 12
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd9,  1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 1'b1); // c6 12+9 wraps
    idle(4'd5, 1'b1);                                                                        // c7
    step(1'b1, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd7,  1'b1, 1'b1, 1'b1); // c8 acc onto 5
    idle(4'd7, 1'b1); idle(4'd7, 1'b1); idle(4'd7, 1'b1); idle(4'd7, 1'b1);                 // c9..c12
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd6,  1'b0, 1'b1, 4'd6,  1'b1, 1'b1, 1'b1); // c13 H load 6
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1); // c14 reset wins
`endif
    idle(4'd0, 1'b0);                                                                        // restart at L_SLOT cnt 0
    idle(4'd0, 1'b0);

    // Timing-channel check: same L stimulus, H silent versus H random.
    for (int i = 0; i < NTR; i++) rl_pat[i] = 1'($urandom_range(0, 1));
    trace_run(1'b0, 1'b0);
    trace_run(1'b1, 1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
